// File: rtl/ifetch_unit_pkg.sv
// Shared types for the instruction-fetch stage: opcode enum, IF/ID payload,
// fetch FSM states and the canonical NOP instruction word.
package ifetch_unit_pkg;

   localparam int unsigned XLEN = 32;

   // addi x0,x0,0
   localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

   typedef enum logic [6:0] {
      op_lui   = 7'b0110111,
      op_auipc = 7'b0010111,
      op_jal   = 7'b1101111,
      op_jalr  = 7'b1100111,
      op_br    = 7'b1100011,
      op_load  = 7'b0000011,
      op_store = 7'b0100011,
      op_imm   = 7'b0010011,
      op_reg   = 7'b0110011,
      op_csr   = 7'b1110011
   } rv32i_opcode;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] inst;
   } if_id_packet_t;

   // REQ: fetching pc.  DROP: stale request in flight, its response is discarded.
   typedef enum logic {
      REQ  = 1'b0,
      DROP = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/ifetch_unit_skid_buf.sv
// fetch_skid_buf: one-entry holding register for a fetched instruction that
// arrived while decode was stalled.
//   clk, rst_n   clock, async active-low reset
//   load         capture load_pkt (buffer becomes valid)
//   drain        buffer contents consumed (buffer becomes empty)
//   clear        flush (redirect); wins over load and drain
//   buf_valid    buffer holds an instruction
//   buf_pkt      buffered IF/ID payload
module fetch_skid_buf
   import ifetch_unit_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  if_id_packet_t load_pkt,
   input  logic          drain,
   input  logic          clear,
   output logic          buf_valid,
   output if_id_packet_t buf_pkt
);

   // Occupancy and payload register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_valid <= 1'b0;
         buf_pkt   <= '0;
      end else if (clear) begin
         buf_valid <= 1'b0;
      end else if (load) begin
         buf_valid <= 1'b1;
         buf_pkt   <= load_pkt;
      end else if (drain) begin
         buf_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: RV32I instruction-fetch stage. Owns the PC, drives the
// instruction-memory request, produces the IF/ID register, absorbs decode
// stalls with a one-entry skid buffer and handles EX redirects.
//   clk, rst_n                 clock, async active-low reset
//   stall                      decode cannot accept a new IF/ID value
//   redirect, redirect_pc      EX PC change request and target
//   inst_mem_read/_address     fetch request and word-aligned address
//   inst_mem_resp/_rdata       fetch response valid and instruction word
//   if_id_valid/_pc/_inst      IF/ID register
//   if_id_opcode/_funct3/_funct7  decode fields sliced from if_id_inst
module ifetch_unit
   import ifetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0060,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        inst_mem_read,
   output logic [31:0] inst_mem_address,
   input  logic        inst_mem_resp,
   input  logic [31:0] inst_mem_rdata,
   output logic        if_id_valid,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_inst,
   output logic [6:0]  if_id_opcode,
   output logic [2:0]  if_id_funct3,
   output logic [6:0]  if_id_funct7
);

   fetch_state_t  state_q, state_d;
   logic [31:0]   pc_q, pc_d;
   logic [31:0]   drop_addr_q, drop_addr_d;
   if_id_packet_t if_id_q, if_id_d;
   logic          fetch_en_q;

   logic          buf_valid, buf_load, buf_drain, buf_clear;
   if_id_packet_t buf_pkt;
   if_id_packet_t fetched_c;
   logic          read_c, fire_c;
   rv32i_opcode   opcode_c;

   // Request is held off until the first edge after reset release so that a
   // response left over from before reset can never be accepted.
   assign read_c    = fetch_en_q & ((state_q == DROP) | ~buf_valid);
   assign fire_c    = read_c & inst_mem_resp;
   assign fetched_c = {1'b1, pc_q, inst_mem_rdata};

   assign inst_mem_read    = read_c;
   assign inst_mem_address = (state_q == DROP) ? drop_addr_q : pc_q;

   assign if_id_valid  = if_id_q.valid;
   assign if_id_pc     = if_id_q.pc;
   assign if_id_inst   = if_id_q.inst;
   assign opcode_c     = rv32i_opcode'(if_id_q.inst[6:0]);
   assign if_id_opcode = opcode_c;
   assign if_id_funct3 = if_id_q.inst[14:12];
   assign if_id_funct7 = if_id_q.inst[31:25];

   fetch_skid_buf u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (buf_load),
      .load_pkt  (fetched_c),
      .drain     (buf_drain),
      .clear     (buf_clear),
      .buf_valid (buf_valid),
      .buf_pkt   (buf_pkt)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= REQ;
         pc_q        <= RESET_PC;
         drop_addr_q <= '0;
         if_id_q     <= '{valid: 1'b0, pc: 32'h0, inst: NOP_INST};
         fetch_en_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         drop_addr_q <= drop_addr_d;
         if_id_q     <= if_id_d;
         fetch_en_q  <= 1'b1;
      end
   end

   // Next-state, PC and IF/ID update
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      drop_addr_d = drop_addr_q;
      if_id_d     = if_id_q;
      buf_load    = 1'b0;
      buf_drain   = 1'b0;
      buf_clear   = 1'b0;

      if (redirect) begin
         // Flush wins over stall and any same-cycle response.
         if_id_d   = '{valid: 1'b0, pc: 32'h0, inst: NOP_INST};
         buf_clear = 1'b1;
         pc_d      = redirect_pc & 32'hFFFF_FFFC;
         if (read_c && !inst_mem_resp) begin
            state_d = DROP;
            // A second redirect while dropping keeps the address of the
            // request actually in flight.
            if (state_q == REQ) begin
               drop_addr_d = pc_q;
            end
         end else begin
            state_d = REQ;
         end
      end else begin
         case (state_q)
            REQ: begin
               if (fire_c) begin
                  // Buffer is empty whenever a request is out.
                  pc_d = pc_q + 32'd4;
                  if (stall) begin
                     buf_load = 1'b1;
                  end else begin
                     if_id_d = fetched_c;
                  end
               end else if (!stall) begin
                  if (buf_valid) begin
                     if_id_d   = buf_pkt;
                     buf_drain = 1'b1;
                  end else begin
                     if_id_d = '{valid: 1'b0, pc: if_id_q.pc, inst: NOP_INST};
                  end
               end
            end
            DROP: begin
               if (fire_c) begin
                  state_d = REQ;
               end
               if (!stall) begin
                  if_id_d = '{valid: 1'b0, pc: if_id_q.pc, inst: NOP_INST};
               end
            end
            default: state_d = REQ;
         endcase
      end
   end

endmodule

// File: tb/tb_ifetch_unit.sv
// Randomised scoreboard bench for ifetch_unit. The driver models the fetch
// stream in program order (next expected fetch PC, redirect kills, stale
// response discard, two-slot IF/ID + skid occupancy) and pushes every
// accepted instruction; a monitor pops whenever decode consumes IF/ID.
module tb_ifetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0060;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        inst_mem_read;
   logic [31:0] inst_mem_address;
   logic        resp = 1'b0;
   logic [31:0] rdata = '0;
   logic        if_id_valid;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_inst;
   logic [6:0]  if_id_opcode;
   logic [2:0]  if_id_funct3;
   logic [6:0]  if_id_funct7;

   int total = 0;
   int bad   = 0;

   exp_t        q[$];
   logic        ifid_full = 1'b0;
   logic        dropping = 1'b0;
   logic        expect_flush = 1'b0;
   logic [31:0] exp_fetch_pc = RESET_PC;
   logic        have_prev = 1'b0;
   logic        prev_read = 1'b0;
   logic        prev_resp = 1'b0;
   logic [31:0] prev_addr = '0;

   ifetch_unit dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .stall            (stall),
      .redirect         (redirect),
      .redirect_pc      (redirect_pc),
      .inst_mem_read    (inst_mem_read),
      .inst_mem_address (inst_mem_address),
      .inst_mem_resp    (resp),
      .inst_mem_rdata   (rdata),
      .if_id_valid      (if_id_valid),
      .if_id_pc         (if_id_pc),
      .if_id_inst       (if_id_inst),
      .if_id_opcode     (if_id_opcode),
      .if_id_funct3     (if_id_funct3),
      .if_id_funct7     (if_id_funct7)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0000_0060) return 32'h0050_0093;
      return (a * 32'h9E37_79B1) ^ {a[15:0], 16'h5A3C};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      ifid_full    = 1'b0;
      dropping     = 1'b0;
      expect_flush = 1'b0;
      exp_fetch_pc = RESET_PC;
      have_prev    = 1'b0;
   endtask

   // One cycle: apply inputs at the falling edge, check the state reached at
   // the previous rising edge, then advance the model over the next one.
   task automatic drive(input logic s, input logic r, input logic [31:0] rp, input logic rs);
      int buffered;
      @(negedge clk);
      stall       = s;
      redirect    = r;
      redirect_pc = rp;
      resp        = rs;
      rdata       = rs ? mem_word(inst_mem_address) : 32'hDEAD_BEEF;

      if (expect_flush) chk("flush", 32'(if_id_valid), 32'd0);
      chk("if_id_valid", 32'(if_id_valid), 32'(ifid_full));
      buffered = q.size() - (ifid_full ? 1 : 0);
      chk("read_ctl", 32'(inst_mem_read), 32'(buffered == 0));
      if (have_prev && prev_read && !prev_resp)
         chk("addr_hold", inst_mem_address, prev_addr);

      expect_flush = 1'b0;
      have_prev    = 1'b1;
      prev_read    = inst_mem_read;
      prev_resp    = rs;
      prev_addr    = inst_mem_address;

      if (r) begin
         q.delete();
         dropping     = inst_mem_read && !rs;
         exp_fetch_pc = rp & 32'hFFFF_FFFC;
         expect_flush = 1'b1;
         ifid_full    = 1'b0;
      end else begin
         if (inst_mem_read && rs) begin
            if (dropping) begin
               dropping = 1'b0;
            end else begin
               chk("fetch_addr", inst_mem_address, exp_fetch_pc);
               q.push_back('{pc: exp_fetch_pc, inst: mem_word(exp_fetch_pc)});
               exp_fetch_pc = exp_fetch_pc + 32'd4;
            end
         end
         if (!s) ifid_full = (q.size() - (ifid_full ? 1 : 0)) > 0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_read", 32'(inst_mem_read), 32'd0);
      chk("rst_valid", 32'(if_id_valid), 32'd0);
      chk("rst_inst", if_id_inst, NOP);
      chk("rst_pc", if_id_pc, 32'd0);
      model_reset();
      stall    = 1'b0;
      redirect = 1'b0;
      resp     = 1'b0;
      repeat (2) @(negedge clk);
      // A response present in the first cycle after release must be ignored.
      resp  = 1'b1;
      rdata = 32'hBAD0_C0DE;
      rst_n = 1'b1;
   endtask

   // Monitor: decode consumes IF/ID on every edge without stall or redirect.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (rst_n) begin
            if (if_id_valid && !stall && !redirect) begin
               if (q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL ifid_unexpected: got valid pc %h want no instruction", if_id_pc);
               end else begin
                  e = q.pop_front();
                  chk("ifid_pc", if_id_pc, e.pc);
                  chk("ifid_inst", if_id_inst, e.inst);
                  chk("ifid_opcode", 32'(if_id_opcode), 32'(e.inst[6:0]));
                  chk("ifid_funct3", 32'(if_id_funct3), 32'(e.inst[14:12]));
                  chk("ifid_funct7", 32'(if_id_funct7), 32'(e.inst[31:25]));
               end
            end
            if (!if_id_valid) chk("bubble_nop", if_id_inst, NOP);
         end
      end
   end

   initial begin
      logic        s, r, rs;
      logic [31:0] rp;

      do_reset();

      // Back-to-back fetches from reset
      drive(0, 0, 0, 1);
      drive(0, 0, 0, 1);
      chk("first_pc", if_id_pc, 32'h60);
      chk("first_opcode", 32'(if_id_opcode), 32'h13);
      chk("first_funct3", 32'(if_id_funct3), 32'd0);
      chk("first_next_addr", inst_mem_address, 32'h64);
      drive(0, 0, 0, 1);
      drive(0, 0, 0, 1);

      // Stall while a response lands: skid fills, request drops, then drains
      drive(1, 0, 0, 1);
      drive(1, 0, 0, 0);
      chk("skid_read_off", 32'(inst_mem_read), 32'd0);
      chk("skid_hold_pc", if_id_pc, 32'h6C);
      drive(0, 0, 0, 0);
      drive(0, 0, 0, 0);
      chk("drain_pc", if_id_pc, 32'h70);
      chk("drain_read", 32'(inst_mem_read), 32'd1);
      chk("drain_addr", inst_mem_address, 32'h74);

      // Redirect with a request outstanding: stale response discarded
      drive(0, 1, 32'h203, 0);
      drive(0, 0, 0, 0);
      chk("drop_valid", 32'(if_id_valid), 32'd0);
      chk("drop_addr", inst_mem_address, 32'h74);
      drive(0, 0, 0, 0);
      drive(0, 0, 0, 1);
      drive(0, 0, 0, 0);
      chk("redir_addr", inst_mem_address, 32'h200);
      drive(0, 0, 0, 1);

      // Redirect + response + stall together
      drive(1, 1, 32'h300, 1);
      drive(0, 0, 0, 0);
      chk("redir_stall_valid", 32'(if_id_valid), 32'd0);
      chk("redir_stall_addr", inst_mem_address, 32'h300);

      // Wrap at the top of the address space, misaligned target
      drive(0, 1, 32'hFFFF_FFFE, 0);
      drive(0, 0, 0, 1);
      drive(0, 0, 0, 1);
      drive(0, 0, 0, 0);
      chk("wrap_addr", inst_mem_address, 32'h0);
      drive(0, 0, 0, 1);

      // Reset in the middle of a request at 0x80
      drive(0, 1, 32'h80, 1);
      drive(0, 0, 0, 0);
      chk("pre_rst_addr", inst_mem_address, 32'h80);
      do_reset();
      drive(0, 0, 0, 0);
      chk("post_rst_read", 32'(inst_mem_read), 32'd1);
      chk("post_rst_addr", inst_mem_address, RESET_PC);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) do_reset();
         s  = ($urandom_range(0, 99) < 30);
         r  = ($urandom_range(0, 99) < 5);
         rs = ($urandom_range(0, 99) < 65);
         if ($urandom_range(0, 3) == 0) rp = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
         else                           rp = $urandom;
         drive(s, r, rp, rs);
      end
      repeat (10) drive(0, 0, 0, 1);
      drive(0, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction-fetch stage of the 5-stage RV32I pipeline; owns the PC and the instruction-memory request handshake.
- Produces the IF/ID register whose opcode/funct3/funct7 fields drive the decode control ROM.
- Absorbs decode stalls with a one-entry skid buffer.
- Handles EX-stage redirects (taken branch, JAL/JALR), including discarding an in-flight response.

Parameters:
- RESET_PC, 32'h00000060, PC fetched first after reset
- NOP_INST, 32'h00000013, instruction word presented on IF/ID when invalid (addi x0,x0,0)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  decode cannot accept a new IF/ID value this cycle
- redirect  in  1  EX requests a PC change; flushes fetch
- redirect_pc  in  32  redirect target
- inst_mem_read  out  1  instruction read request
- inst_mem_address  out  32  request address, word aligned
- inst_mem_resp  in  1  read data valid; only meaningful while inst_mem_read=1
- inst_mem_rdata  in  32  instruction word
- if_id_valid  out  1  IF/ID holds a real instruction
- if_id_pc  out  32  PC of the IF/ID instruction
- if_id_inst  out  32  IF/ID instruction word
- if_id_opcode  out  7  if_id_inst[6:0] as rv32i_opcode, combinational
- if_id_funct3  out  3  if_id_inst[14:12], combinational
- if_id_funct7  out  7  if_id_inst[31:25], combinational

Behaviour:
- Reset (async, while rst_n=0):
  - pc=RESET_PC, state=REQ, skid buffer empty
  - if_id_valid=0, if_id_pc=0, if_id_inst=NOP_INST
  - inst_mem_read=0
- First cycle after release: inst_mem_read=1, inst_mem_address=RESET_PC.
- States:
  - REQ: issuing fetch of pc.
  - DROP: a request to the stale address is in flight and its response must be discarded.
- Request rule: inst_mem_address is held stable while inst_mem_read=1 and inst_mem_resp=0.
  - REQ: inst_mem_read = !buf_valid.
  - DROP: inst_mem_read = 1.
- Response latency: at least 1 cycle; the memory may respond every cycle.
- REQ, resp=1, redirect=0:
  - stall=0 and buffer empty: IF/ID <= {1, pc, rdata}; pc <= pc+4. Throughput is 1 instr/cycle.
  - stall=1: response captured in the skid buffer (buf_valid=1); IF/ID holds; pc <= pc+4; request deasserts next cycle.
- Buffer drain: buf_valid=1 and stall=0 -> IF/ID <= buffer, buf_valid <= 0, request resumes the next cycle.
- stall=1 with no response: IF/ID holds unchanged, including if_id_valid.
- stall=0 with nothing to deliver: if_id_valid <= 0 and if_id_inst <= NOP_INST (bubble).
- Redirect (priority over stall and resp):
  - IF/ID <= {0, 0, NOP_INST}; buf_valid <= 0; pc <= {redirect_pc[31:2], 2'b00}.
  - Request outstanding (read=1, resp=0) -> next state DROP.
  - Otherwise, or resp=1 in the same cycle -> that data is discarded, next state REQ.
- DROP:
  - Holds the old address until resp=1; the data is discarded and the next state is REQ at the new pc.
  - A further redirect in DROP updates pc and stays in DROP.
  - IF/ID stays invalid.
- Arithmetic: pc+4 is modulo 2^32, so 32'hFFFFFFFC wraps to 0. Misaligned targets are silently aligned; no exception.
- Async reset mid-request: the request is abandoned immediately. Any response arriving after release and before the first new request is ignored.

Decomposition:
- rv32i_types (existing): rv32i_opcode.
- rv32i_packet, new additions:
  - if_id_packet_t {valid, pc, inst}
  - fetch_state_t {REQ, DROP}
  - NOP_INST constant
- Sub-module fetch_skid_buf: one-entry if_id_packet_t buffer with load/drain/clear and buf_valid.

Test Plan:
- Reset release -> read=1 at 0x60. Resp=1 next cycle with 0x00500093 -> if_id_valid=1, pc=0x60, opcode=op_imm, funct3=0; address becomes 0x64.
- Resp every cycle for 4 fetches -> IF/ID pc 0x60, 0x64, 0x68, 0x6C on consecutive cycles, no bubbles.
- stall=1 while resp for 0x64 arrives -> IF/ID holds 0x60, read=0 next cycle. Drop stall -> IF/ID=0x64 next cycle, then read=1 at 0x68.
- Read outstanding at 0x68, redirect=1 to 0x203 with no resp -> next cycle if_id_valid=0, address stays 0x68. Resp after 3 cycles is discarded; following cycle address=0x200.
- Redirect and resp in the same cycle, plus stall=1 -> data dropped, IF/ID flushed despite stall, next address=redirect target. Also: pc=0xFFFFFFFC fetch -> next address 0x00000000.
- rst_n low mid-request at 0x80 -> outputs reset immediately (read=0, if_id_valid=0, if_id_inst=0x00000013). Release -> read=1 at 0x60.
